instr_encoder_loader: RTL and testbench

- Inverse of the core's instruction decode path: accepts field-level instruction requests, encodes each into a 32-bit RV32I word, and writes the words sequentially into instruction memory.
- Used by the bring-up/test infrastructure to load programs into IMEM without an external assembler.
- Structure: a combinational encoder feeding a small FIFO, which drains through a ready-gated IMEM write port with an auto-incrementing address.

---
 rtl/instr_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes field-level RV32I requests into instruction words and streams them
// through a small show-ahead FIFO into IMEM at auto-incrementing addresses.
module instr_encoder_loader #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_class_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  input  logic              finish_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W-2:0] word_count_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {LOAD, FINISHING} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-2:0]   wcount_q, wcount_d;
  logic                err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_valid;
  logic        fifo_empty, fifo_full, finish_pending;
  logic        accept, push, pop;

  always_comb begin
    enc_word  = '0;
    enc_valid = 1'b1;
    unique case (op_class_i)
      3'd0: enc_word = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      3'd1: begin
        // Shift-immediates carry funct7 in the upper immediate bits
        if (funct3_i == 3'b001 || funct3_i == 3'b101)
          enc_word = {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, 7'b0010011};
        else
          enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
      end
      3'd2: enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
      3'd3: enc_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
      3'd4: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], 7'b1100011};
      3'd5: enc_word = {imm_i[31:12], rd_i, 7'b0110111};
      3'd6: enc_word = {imm_i[31:12], rd_i, 7'b0010111};
      default: enc_valid = 1'b0;
    endcase
  end

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign finish_pending = (state_q == FINISHING);

  assign req_ready_o  = !reset_i && !fifo_full && !finish_pending;
  assign accept       = req_valid_i && req_ready_o;
  assign push         = accept && enc_valid;
  assign pop          = imem_we_o && imem_ready_i;

  assign imem_we_o    = !fifo_empty;
  assign imem_wdata_o = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign imem_addr_o  = addr_q;
  assign word_count_o = wcount_q;
  assign done_o       = finish_pending && fifo_empty;
  assign err_o        = err_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wcount_d = wcount_q;
    err_d    = err_q || (accept && !enc_valid);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(4);
      wcount_d = wcount_q + (ADDR_W-1)'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Completion can only fire with the FIFO empty, so it never races a pop
    unique case (state_q)
      LOAD:      if (finish_i) state_d = FINISHING;
      FINISHING: if (fifo_empty) begin
        state_d  = LOAD;
        addr_d   = BASE_ADDR;
        wcount_d = '0;
      end
      default:   state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      wcount_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader, checked every cycle
// against a queue-based model of the loader.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int unsigned BASE = 0;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [2:0]    op_class_i = '0;
  logic [2:0]    funct3_i = '0;
  logic          funct7b5_i = 1'b0;
  logic [4:0]    rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [31:0]   imm_i = '0;
  logic          finish_i = 1'b0;
  logic          imem_we_o;
  logic          imem_ready_i = 1'b0;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic [AW-2:0] word_count_o;
  logic          done_o;
  logic          err_o;

  always #5 clk = ~clk;

  instr_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(AW'(BASE))) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_class_i(op_class_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .finish_i(finish_i),
    .imem_we_o(imem_we_o), .imem_ready_i(imem_ready_i),
    .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .word_count_o(word_count_o), .done_o(done_o), .err_o(err_o)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the RV32I field layouts with plain arithmetic
  function automatic logic [31:0] encodeRef(input int unsigned op, f3, f7, rd, rs1, rs2, imm);
    int unsigned w;
    case (op)
      0: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: if (f3 == 1 || f3 == 5)
           w = (f7 << 30) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         else
           w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
      3: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
             | ((imm & 31) << 7) | 32'h23;
      4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 1) << 7) | 32'h63;
      5: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      6: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
      default: w = 0;
    endcase
    return w;
  endfunction

  logic [31:0] mq[$];
  int unsigned mAddr = BASE, mWc = 0;
  bit mPend = 1'b0, mErr = 1'b0;

  always @(posedge clk) begin
    bit doneNow, rdy, acc;
    if (reset_i) begin
      mq.delete();
      mAddr = BASE; mWc = 0; mPend = 1'b0; mErr = 1'b0;
    end else begin
      doneNow = mPend && (mq.size() == 0);
      rdy     = (mq.size() < DEPTH) && !mPend;
      acc     = req_valid_i && rdy;
      if (mq.size() > 0 && imem_ready_i) begin
        void'(mq.pop_front());
        mAddr = (mAddr + 4) % (1 << AW);
        mWc   = (mWc + 1) % (1 << (AW - 1));
      end
      if (acc) begin
        if (op_class_i == 3'd7) mErr = 1'b1;
        else mq.push_back(encodeRef(op_class_i, funct3_i, funct7b5_i, rd_i, rs1_i, rs2_i, imm_i));
      end
      if (doneNow) begin
        mAddr = BASE; mWc = 0; mPend = 1'b0;
      end else if (finish_i) mPend = 1'b1;
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk) begin
      checkOutput("req_ready", 32'(req_ready_o), 32'(!reset_i && mq.size() < DEPTH && !mPend));
      checkOutput("imem_we", 32'(imem_we_o), 32'(mq.size() > 0));
      checkOutput("imem_wdata", imem_wdata_o, (mq.size() > 0) ? mq[0] : 32'h0);
      checkOutput("imem_addr", 32'(imem_addr_o), mAddr);
      checkOutput("word_count", 32'(word_count_o), mWc);
      checkOutput("done", 32'(done_o), 32'(mPend && mq.size() == 0));
      checkOutput("err", 32'(err_o), 32'(mErr));
    end
  end

  bit logW = 1'b0;
  logic [31:0] obsA[$], obsD[$];
  always @(negedge clk) begin
    #1;
    if (logW && imem_we_o && imem_ready_i) begin
      obsA.push_back(32'(imem_addr_o));
      obsD.push_back(imem_wdata_o);
    end
  end

  int unsigned opT [8] = '{1, 0, 0, 2, 3, 4, 5, 1};
  int unsigned f3T [8] = '{0, 0, 0, 0, 0, 0, 0, 5};
  int unsigned f7T [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
  int unsigned rdT [8] = '{1, 3, 3, 5, 0, 0, 10, 1};
  int unsigned rs1T[8] = '{0, 1, 1, 2, 2, 1, 0, 1};
  int unsigned rs2T[8] = '{0, 2, 2, 0, 5, 2, 0, 0};
  int unsigned immT[8] = '{5, 0, 0, 8, 12, 32'hFFFFFFFC, 32'h12345000, 3};
  logic [31:0] litT[8] = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h00812283,
                           32'h00512623, 32'hFE208EE3, 32'h12345537, 32'h4030D093};

  task automatic applyStimulus(input bit v, input int unsigned op, f3, f7, rd, rs1, rs2, imm,
                               input bit fin, input bit rdy, input bit rst);
    @(negedge clk);
    req_valid_i = v;        op_class_i = 3'(op);   funct3_i = 3'(f3);
    funct7b5_i  = f7[0];    rd_i = 5'(rd);         rs1_i = 5'(rs1);  rs2_i = 5'(rs2);
    imm_i = imm;            finish_i = fin;        imem_ready_i = rdy; reset_i = rst;
  endtask

  task automatic reqT(input int i, input bit rdy);
    applyStimulus(1'b1, opT[i], f3T[i], f7T[i], rdT[i], rs1T[i], rs2T[i], immT[i], 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy, input bit fin = 1'b0, input bit rst = 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, fin, rdy, rst);
  endtask

  task automatic clearLog();
    obsA.delete(); obsD.delete();
  endtask

  initial begin
    int pulses, wcAtDone, wcAfterDone;
    bit seenDone, acc;

    @(posedge clk);
    #1 chk = 1'b1;

    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("encRef%0d", i),
                  encodeRef(opT[i], f3T[i], f7T[i], rdT[i], rs1T[i], rs2T[i], immT[i]), litT[i]);

    // Encoding set, one request per cycle
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b1);
    #2;
    checkOutput("rstAddr", 32'(imem_addr_o), BASE);
    checkOutput("rstWe", 32'(imem_we_o), 0);
    clearLog(); logW = 1'b1;
    for (int i = 0; i < 8; i++) reqT(i, 1'b1);
    repeat (4) idle(1'b1);
    checkOutput("encCount", obsD.size(), 8);
    for (int i = 0; i < 8 && i < obsD.size(); i++) begin
      checkOutput($sformatf("encAddr%0d", i), obsA[i], 32'(4 * i));
      checkOutput($sformatf("encWord%0d", i), obsD[i], litT[i]);
    end

    // Backpressure with a full FIFO
    idle(1'b0, 1'b0, 1'b1);
    clearLog();
    for (int i = 0; i < 4; i++) reqT(i, 1'b0);
    for (int k = 0; k < 3; k++) begin
      reqT(4, 1'b0);
      #2;
      checkOutput("bpReady", 32'(req_ready_o), 0);
      checkOutput("bpAddr", 32'(imem_addr_o), BASE);
      checkOutput("bpWdata", imem_wdata_o, litT[0]);
    end
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      reqT(4, 1'b1);
      #2;
      if (req_ready_o) acc = 1'b1;
    end
    checkOutput("bpAccept5", 32'(acc), 1);
    repeat (4) idle(1'b1);
    checkOutput("bpCount", obsD.size(), 5);
    for (int i = 0; i < 5 && i < obsD.size(); i++) begin
      checkOutput($sformatf("bpAddr%0d", i), obsA[i], 32'(4 * i));
      checkOutput($sformatf("bpWord%0d", i), obsD[i], litT[i]);
    end

    // finish with three queued words and a toggling ready
    idle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) reqT(i, 1'b0);
    idle(1'b0, 1'b1);
    pulses = 0; wcAtDone = -1; wcAfterDone = -1; seenDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      idle(k[0]);
      #2;
      if (seenDone && wcAfterDone < 0) wcAfterDone = int'(word_count_o);
      if (done_o) begin
        pulses++;
        if (!seenDone) wcAtDone = int'(word_count_o);
        seenDone = 1'b1;
      end
    end
    checkOutput("finDonePulses", pulses, 1);
    checkOutput("finWcAtDone", wcAtDone, 3);
    checkOutput("finWcAfterDone", wcAfterDone, 0);
    checkOutput("finAddrAfter", 32'(imem_addr_o), BASE);

    // Invalid op between two valid requests
    idle(1'b1, 1'b0, 1'b1);
    clearLog();
    reqT(0, 1'b1);
    applyStimulus(1'b1, 7, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    reqT(1, 1'b1);
    repeat (6) idle(1'b1);
    checkOutput("errSticky", 32'(err_o), 1);
    checkOutput("errCount", obsD.size(), 2);
    for (int i = 0; i < 2 && i < obsD.size(); i++) begin
      checkOutput($sformatf("errAddr%0d", i), obsA[i], 32'(4 * i));
      checkOutput($sformatf("errWord%0d", i), obsD[i], litT[i]);
    end

    // Reset while the FIFO holds two words
    reqT(2, 1'b0);
    reqT(3, 1'b0);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b1);
    #2;
    checkOutput("midRstWe", 32'(imem_we_o), 0);
    checkOutput("midRstAddr", 32'(imem_addr_o), BASE);
    checkOutput("midRstErr", 32'(err_o), 0);
    checkOutput("midRstWc", 32'(word_count_o), 0);
    clearLog();
    repeat (5) idle(1'b1);
    checkOutput("midRstStale", obsD.size(), 0);
    logW = 1'b0;

    // Long random stream without finish, long enough to wrap the address
    for (int k = 0; k < 1500; k++)
      applyStimulus($urandom_range(0, 99) < 80, ($urandom_range(0, 31) == 0) ? 7 : $urandom_range(0, 6),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom,
                    1'b0, $urandom_range(0, 99) < 85, 1'b0);

    // Random stream with finish and occasional reset
    for (int k = 0; k < 2500; k++)
      applyStimulus($urandom_range(0, 99) < 70, ($urandom_range(0, 31) == 0) ? 7 : $urandom_range(0, 6),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 199) == 0);

    idle(1'b1);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
